// File: rtl/ysyx_24080014_lsu_pkg.sv
// Shared LSU types: FSM state encoding, exception codes, funct3 constants
// and the request legality check used when a request is accepted.
package ysyx_24080014_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // ILLEGAL takes priority over MISALIGN; non-memory requests never fault.
  function automatic logic [1:0] lsu_check(input logic       is_load,
                                           input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic illegal;
    logic misalign;
    illegal = is_load && is_store;
    if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
      illegal = 1'b1;
    if (is_store && !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW))
      illegal = 1'b1;
    misalign = ((funct3 == F3_LH || funct3 == F3_LHU) && addr_lo[0]) ||
               ((funct3 == F3_LW) && (addr_lo != 2'b00));
    if (!is_load && !is_store) return EXC_NONE;
    if (illegal)               return EXC_ILLEGAL;
    if (misalign)              return EXC_MISALIGN;
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// Load lane extraction and sign/zero extension of a memory word. Latency: combinational.
// Backpressure: none, pure function of its inputs.
module ysyx_24080014_lsu_align
  import ysyx_24080014_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = 32'd0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one memory access per request. Latency: 1 cycle non-memory/fault, 3+ with memory.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, WAIT aborts after TIMEOUT cycles.
module ysyx_24080014_lsu
  import ysyx_24080014_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic        mem_inst_ready,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_exc
);

  localparam logic [3:0] TO_LIM = 4'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;
  logic        is_store_q, is_store_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_exc_q, out_exc_d;

  logic [1:0]  req_exc;
  logic [31:0] load_data;
  logic [4:0]  lane_shamt;

  assign req_exc    = lsu_check(is_load, is_store, funct3, addr[1:0]);
  assign lane_shamt = {addr_q[1:0], 3'b000};

  ysyx_24080014_lsu_align u_align (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (mem_rdata),
    .data    (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    is_store_d   = is_store_q;
    out_data_d   = out_data_q;
    out_exc_d    = out_exc_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          addr_d       = addr;
          store_data_d = store_data;
          funct3_d     = funct3;
          is_load_d    = is_load;
          is_store_d   = is_store;
          cnt_d        = 4'd0;
          if (req_exc != EXC_NONE) begin
            out_exc_d  = req_exc;
            out_data_d = 32'd0;
            state_d    = ST_DONE;
          end else if (!is_load && !is_store) begin
            out_exc_d  = EXC_NONE;
            out_data_d = alu_result;
            state_d    = ST_DONE;
          end else begin
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        cnt_d   = 4'd1;
      end
      ST_WAIT: begin
        if (mem_ready) begin
          out_exc_d  = EXC_NONE;
          out_data_d = is_load_q ? load_data : 32'd0;
          state_d    = ST_DONE;
        end else if (cnt_q >= TO_LIM) begin
          out_exc_d  = EXC_TIMEOUT;
          out_data_d = 32'd0;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'd0;
      store_data_q <= 32'd0;
      funct3_q     <= 3'd0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      out_data_q   <= 32'd0;
      out_exc_q    <= EXC_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      funct3_q     <= funct3_d;
      is_load_q    <= is_load_d;
      is_store_q   <= is_store_d;
      out_data_q   <= out_data_d;
      out_exc_q    <= out_exc_d;
    end
  end

  // Memory strobes are decoded from state alone so they last exactly the one REQ cycle.
  always_comb begin
    in_ready       = (state_q == ST_IDLE);
    out_valid      = (state_q == ST_DONE);
    out_data       = out_valid ? out_data_q : 32'd0;
    out_exc        = out_valid ? out_exc_q : EXC_NONE;
    mem_inst_ready = 1'b0;
    mem_ren        = 1'b0;
    mem_wen        = 1'b0;
    mem_waddr      = 32'd0;
    mem_raddr      = 32'd0;
    mem_wmask      = 8'd0;
    mem_wdata      = 32'd0;
    if (state_q == ST_REQ) begin
      mem_inst_ready = 1'b1;
      mem_ren        = is_load_q;
      mem_wen        = is_store_q;
      mem_waddr      = {addr_q[31:2], 2'b00};
      mem_raddr      = {addr_q[31:2], 2'b00};
      if (is_store_q) begin
        case (funct3_q)
          F3_SB: begin
            mem_wmask = {4'd0, 4'b0001 << addr_q[1:0]};
            mem_wdata = {24'd0, store_data_q[7:0]} << lane_shamt;
          end
          F3_SH: begin
            mem_wmask = {4'd0, 4'b0011 << addr_q[1:0]};
            mem_wdata = {16'd0, store_data_q[15:0]} << lane_shamt;
          end
          F3_SW: begin
            mem_wmask = 8'h0F;
            mem_wdata = store_data_q;
          end
          default: begin
            mem_wmask = 8'd0;
            mem_wdata = 32'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Self-checking bench for ysyx_24080014_lsu: vector table plus reset/backpressure/timeout sequences.
module tb_ysyx_24080014_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0, alu_result = 32'd0;
  logic        mem_wen, mem_ren, mem_inst_ready;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_waddr, mem_raddr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_exc;

  always #5 clk = ~clk;

  ysyx_24080014_lsu #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .alu_result(alu_result),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_inst_ready(mem_inst_ready),
    .mem_wmask(mem_wmask), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_exc(out_exc)
  );

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, alu, rdata;
    logic        hold;
    logic [31:0] exp_data;
    logic [1:0]  exp_exc;
    int          exp_lat;
    int          exp_req;
    logic [7:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  exc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] sd, logic [31:0] alu, logic [31:0] rd, logic hold,
                              logic [31:0] ed, logic [1:0] ee, int lat, int req,
                              logic [7:0] em, logic [31:0] ew);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd; v.alu = alu;
    v.rdata = rd; v.hold = hold; v.exp_data = ed; v.exp_exc = ee;
    v.exp_lat = lat; v.exp_req = req; v.exp_mask = em; v.exp_wdata = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; alu_result = alu;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    is_load = 1'($urandom()); is_store = 1'($urandom()); funct3 = 3'($urandom());
    addr = $urandom(); store_data = $urandom(); alu_result = $urandom();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   lat, nreq, nstray;
    bit   got;
    exp_t e;
    drive_req(v.ld, v.st, v.f3, v.addr, v.sdata, v.alu);
    sb.push_back('{data: v.exp_data, exc: v.exp_exc});
    lat = 0; nreq = 0; nstray = 0; got = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((mem_wen || mem_ren) && !mem_inst_ready) nstray++;
      if (mem_inst_ready) begin
        nreq++;
        chk($sformatf("v%0d_waddr", idx), mem_waddr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_raddr", idx), mem_raddr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_wen", idx), mem_wen, v.st);
        chk($sformatf("v%0d_ren", idx), mem_ren, v.ld);
        chk($sformatf("v%0d_wmask", idx), mem_wmask, v.exp_mask);
        if (v.st) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.exp_wdata);
        if (!v.hold) begin
          mem_ready = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      if (out_valid) begin
        lat = c;
        got = 1;
        break;
      end
    end
    mem_ready = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_req_cycles", idx), nreq, v.exp_req);
    chk($sformatf("v%0d_stray_strobes", idx), nstray, 0);
    e = sb.pop_front();
    if (got) begin
      chk($sformatf("v%0d_out_data", idx), out_data, e.data);
      chk($sformatf("v%0d_out_exc", idx), out_exc, e.exc);
    end else begin
      checks++;
      failures++;
      $display("FAIL v%0d_no_output actual=none expected=out_valid", idx);
    end
    @(posedge clk);
  endtask

  initial begin
    exp_t e;
    bit   got;

    vecs.push_back(mk(0,1,3'b000,32'h80000003,32'h000000AB,0,32'hFFFFFFFF,0, 32'h0,2'd0,3,1,8'h08,32'hAB000000));
    vecs.push_back(mk(1,0,3'b000,32'h80000002,0,0,32'h12F03456,0, 32'hFFFFFFF0,2'd0,3,1,8'h00,0));
    vecs.push_back(mk(1,0,3'b100,32'h80000002,0,0,32'h12F03456,0, 32'h000000F0,2'd0,3,1,8'h00,0));
    vecs.push_back(mk(1,0,3'b010,32'h80000006,0,0,32'h0,0, 32'h0,2'd1,1,0,8'h00,0));
    vecs.push_back(mk(1,0,3'b001,32'h80000002,0,0,32'h80011234,0, 32'hFFFF8001,2'd0,3,1,8'h00,0));
    vecs.push_back(mk(1,0,3'b101,32'h80000000,0,0,32'h12349ABC,0, 32'h00009ABC,2'd0,3,1,8'h00,0));
    vecs.push_back(mk(1,0,3'b010,32'h80000004,0,0,32'hDEADBEEF,0, 32'hDEADBEEF,2'd0,3,1,8'h00,0));
    vecs.push_back(mk(0,1,3'b001,32'h80000002,32'h12345678,0,32'hFFFFFFFF,0, 32'h0,2'd0,3,1,8'h0C,32'h56780000));
    vecs.push_back(mk(0,1,3'b010,32'h80000008,32'hCAFEF00D,0,32'hFFFFFFFF,0, 32'h0,2'd0,3,1,8'h0F,32'hCAFEF00D));
    vecs.push_back(mk(0,1,3'b000,32'h80000001,32'h112233CD,0,32'hFFFFFFFF,0, 32'h0,2'd0,3,1,8'h02,32'h0000CD00));
    vecs.push_back(mk(0,0,3'b111,32'h80000001,0,32'h13572468,0,0, 32'h13572468,2'd0,1,0,8'h00,0));
    vecs.push_back(mk(1,0,3'b011,32'h80000000,0,0,0,0, 32'h0,2'd2,1,0,8'h00,0));
    vecs.push_back(mk(1,1,3'b010,32'h80000001,0,0,0,0, 32'h0,2'd2,1,0,8'h00,0));
    vecs.push_back(mk(0,1,3'b100,32'h80000000,0,0,0,0, 32'h0,2'd2,1,0,8'h00,0));
    vecs.push_back(mk(0,1,3'b001,32'h80000001,0,0,0,0, 32'h0,2'd1,1,0,8'h00,0));
    vecs.push_back(mk(1,0,3'b101,32'h80000003,0,0,0,0, 32'h0,2'd1,1,0,8'h00,0));
    vecs.push_back(mk(1,0,3'b000,32'h80000003,0,0,32'h7F000000,0, 32'h0000007F,2'd0,3,1,8'h00,0));
    vecs.push_back(mk(1,0,3'b010,32'h80000010,0,0,32'h0,1, 32'h0,2'd3,17,1,8'h00,0));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_mem_strobes", {mem_wen, mem_ren, mem_inst_ready}, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Stray mem_ready after the timeout above must not produce a result.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h5555AAAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("late_ready_out_valid", out_valid, 0);
      chk("late_ready_in_ready", in_ready, 1);
    end
    mem_ready = 1'b0;

    // Held result under backpressure while mem_ready/mem_rdata keep moving.
    out_ready = 1'b0;
    drive_req(1, 0, 3'b000, 32'h80000001, 0, 0);
    sb.push_back('{data: 32'hFFFFFF80, exc: 2'd0});
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_inst_ready) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h00008000;
      end
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    chk("bp_got_output", got, 1);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      mem_rdata = $urandom();
      mem_ready = ~mem_ready;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, e.data);
      chk("bp_out_exc", out_exc, e.exc);
      chk("bp_in_ready", in_ready, 0);
    end
    mem_ready = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // Asynchronous reset while in WAIT abandons the access.
    drive_req(1, 0, 3'b010, 32'h80000040, 0, 0);
    @(negedge clk);
    chk("rw_req_seen", mem_inst_ready, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_in_ready", in_ready, 1);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_out_data", out_data, 0);
    chk("rw_out_exc", out_exc, 0);
    chk("rw_strobes", {mem_wen, mem_ren, mem_inst_ready}, 0);
    chk("rw_wmask", mem_wmask, 0);
    chk("rw_waddr", mem_waddr, 0);
    chk("rw_raddr", mem_raddr, 0);
    chk("rw_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rw_after_out_valid", out_valid, 0);
      chk("rw_after_in_ready", in_ready, 1);
    end
    mem_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_24080014_lsu.md
YSYX_24080014_LSU -- requirements
Module: ysyx_24080014_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max WAIT cycles before abort (1..15).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have in_valid in 1, in_ready out 1: request handshake from execute stage.
REQ-005 SHALL have is_load in 1, is_store in 1, funct3 in 3, addr in 32, store_data in 32, alu_result in 32: request payload.
REQ-006 SHALL have mem_wen out 1, mem_ren out 1, mem_inst_ready out 1, mem_wmask out 8, mem_waddr out 32, mem_raddr out 32, mem_wdata out 32: memory-stage request.
REQ-007 SHALL have mem_ready in 1, mem_rdata in 32: memory-stage completion and read data.
REQ-008 SHALL have out_valid out 1, out_ready in 1, out_data out 32, out_exc out 2: result handshake to writeback.

Function
REQ-009 SHALL implement FSM IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE.
REQ-010 SHALL, in IDLE on in_valid&&in_ready, register all payload; next state DONE if exception or non-memory (is_load=is_store=0), else REQ.
REQ-011 SHALL, in REQ, assert mem_inst_ready plus mem_ren (load) or mem_wen (store) for exactly one cycle, then enter WAIT.
REQ-012 SHALL never assert mem_wen/mem_ren/mem_inst_ready outside REQ (memory stage re-samples every edge; double assertion = double write).
REQ-013 SHALL drive mem_waddr=mem_raddr={addr[31:2],2'b00} from registered addr; 0 outside REQ.
REQ-014 SHALL drive mem_wmask[7:4]=0; [3:0]: sb 4'b0001<<addr[1:0], sh 4'b0011<<addr[1:0], sw 4'b1111; 0 for loads/idle.
REQ-015 SHALL drive mem_wdata = store_data lane-shifted left by 8*addr[1:0] (sb byte, sh half, sw unshifted).
REQ-016 SHALL, in WAIT, on mem_ready latch mem_rdata, extract lane addr[1:0]: lb/lh sign-extend, lbu/lhu zero-extend, lw whole word; store result 0; go DONE.
REQ-017 SHALL count WAIT cycles from 1; if count reaches TIMEOUT without mem_ready, go DONE with out_exc=TIMEOUT, out_data=0.
REQ-018 SHALL ignore mem_ready outside WAIT.
REQ-019 SHALL flag out_exc=MISALIGN when lh/lhu/sh with addr[0]=1 or lw/sw with addr[1:0]!=0; no memory request issued, out_data=0.
REQ-020 SHALL flag out_exc=ILLEGAL for load funct3 in {011,110,111}, store funct3 not in {000,001,010}, or is_load&&is_store; no memory request; ILLEGAL beats MISALIGN.
REQ-021 SHALL pass alu_result to out_data with out_exc=NONE for non-memory requests.
REQ-022 SHALL hold out_valid=1 and out_data/out_exc stable in DONE until out_ready; on out_valid&&out_ready go IDLE (no same-cycle accept of next request).
REQ-023 SHALL give latency in_accept->out_valid: 1 cycle non-memory/exception, 3 cycles with mem_ready in first WAIT cycle.

Reset
REQ-024 SHALL on rst_n=0, asynchronously, set state IDLE, counter 0, all registered payload 0, outputs in_ready=1, out_valid=0, out_data=0, out_exc=NONE, all mem_* outputs 0.
REQ-025 SHALL, on reset in REQ/WAIT, abandon the access; a subsequent stray mem_ready is ignored per REQ-018.

Structure
REQ-026 SHALL place state encoding, out_exc codes (NONE=0, MISALIGN=1, ILLEGAL=2, TIMEOUT=3) and funct3 constants in shared package ysyx_24080014_pkg.
REQ-027 SHALL isolate lane extraction/sign-extension in combinational sub-module ysyx_24080014_lsu_align.

Verification
REQ-028 SHALL check sb addr=0x80000003 store_data=0x000000AB -> one-cycle mem_wen, waddr 0x80000000, wmask 0x08, wdata 0xAB000000.
REQ-029 SHALL check lb addr=0x80000002, mem_rdata=0x12F03456 -> out_data 0xFFFFFFF0; lbu same -> 0x000000F0.
REQ-030 SHALL check lw addr=0x80000006 -> out_exc=1, no mem_ren, out_valid after 1 cycle.
REQ-031 SHALL check load with mem_ready withheld -> out_exc=3 after 15 WAIT cycles; late mem_ready ignored.
REQ-032 SHALL check out_ready low 5 cycles in DONE -> out_data stable, in_ready=0; rst_n low in WAIT -> all outputs reset values immediately.
